// File: rtl/vid_out.sv
// Video output stage: pixel FIFO, raster timing generator and stream error flags.
// The FIFO is flushed at the start of vertical blanking, when the display engine is asked for a new frame.
module vid_out #(
    parameter int unsigned H_ACTIVE   = 800,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 1024,
    parameter int unsigned V_FP       = 3,
    parameter int unsigned V_SYNC     = 3,
    parameter int unsigned V_BP       = 30,
    parameter int unsigned FIFO_DEPTH = 2048
) (
    input  logic clk,
    input  logic rstn,
    input  logic pixel_valid,
    input  logic pixel,
    output logic pixel_ready,
    input  logic vid_ce,
    output logic vid_hsync,
    output logic vid_vsync,
    output logic vid_de,
    output logic vid_pixel,
    output logic frame_start,
    output logic underflow,
    output logic overflow,
    input  logic clr_err
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CW      = 12;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] CNT_INC  = CW'(1);
    localparam logic [AW:0]   PTR_INC  = (AW + 1)'(1);

    logic [CW-1:0]         r_hcnt;
    logic [CW-1:0]         r_vcnt;
    logic [AW:0]           r_wptr;
    logic [AW:0]           r_rptr;
    logic [FIFO_DEPTH-1:0] r_mem;
    logic                  r_hsync;
    logic                  r_vsync;
    logic                  r_de;
    logic                  r_pixel;
    logic                  r_frame_start;
    logic                  r_underflow;
    logic                  r_overflow;

    logic w_full;
    logic w_empty;
    logic w_active;
    logic w_hs;
    logic w_vs;
    logic w_fsync;
    logic w_push;
    logic w_pop;
    logic w_uf_set;
    logic w_of_set;
    logic w_rd_data;

    // FIFO status and raster region decode from the pre-cycle state
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty   = (r_wptr == r_rptr);
    assign w_active  = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
    assign w_hs      = (r_hcnt >= HS_BEG) && (r_hcnt < HS_END);
    assign w_vs      = (r_vcnt >= VS_BEG) && (r_vcnt < VS_END);
    assign w_fsync   = vid_ce && (r_hcnt == '0) && (r_vcnt == V_ACT);
    assign w_push    = pixel_valid && !w_full && !w_fsync;
    assign w_pop     = vid_ce && w_active && !w_empty;
    assign w_uf_set  = vid_ce && w_active && w_empty;
    assign w_of_set  = pixel_valid && w_full && !w_fsync;
    assign w_rd_data = r_mem[r_rptr[AW-1:0]];

    assign pixel_ready = !w_full;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_de          <= 1'b0;
            r_pixel       <= 1'b0;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (vid_ce) begin
                if (r_hcnt == H_LAST) begin
                    r_hcnt <= '0;
                    r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + CNT_INC;
                end else begin
                    r_hcnt <= r_hcnt + CNT_INC;
                end
                r_hsync <= !w_hs;
                r_vsync <= !w_vs;
                r_de    <= w_active;
                r_pixel <= w_pop && w_rd_data;
            end
            r_frame_start <= w_fsync;
            // Flush realigns the stream to the new frame fetch
            if (w_fsync) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + PTR_INC;
                if (w_pop)  r_rptr <= r_rptr + PTR_INC;
            end
            r_underflow <= (r_underflow && !clr_err) || w_uf_set;
            r_overflow  <= (r_overflow && !clr_err) || w_of_set;
        end
    end

    assign vid_hsync   = r_hsync;
    assign vid_vsync   = r_vsync;
    assign vid_de      = r_de;
    assign vid_pixel   = r_pixel;
    assign frame_start = r_frame_start;
    assign underflow   = r_underflow;
    assign overflow    = r_overflow;

endmodule

// File: doc/vid_out.md
# vid_out

Video output stage downstream of the display DMA engine. It takes the 1-bit `pixel_valid`/`pixel` stream and buffers it in a pixel FIFO. It generates raster timing (hsync/vsync/data-enable) and emits one pixel per active video slot. It also tells the display engine when to start fetching a new frame and reports stream under- and overflow.

## Interface
- `H_ACTIVE`, 800, visible pixels per line
- `H_FP`, 16, horizontal front porch (slots)
- `H_SYNC`, 96, hsync width (slots)
- `H_BP`, 48, horizontal back porch (slots)
- `V_ACTIVE`, 1024, visible lines per frame
- `V_FP`, 3, vertical front porch (lines)
- `V_SYNC`, 3, vsync width (lines)
- `V_BP`, 30, vertical back porch (lines)
- `FIFO_DEPTH`, 2048, pixel FIFO entries; power of two, ≥ 4
- `clk`  in  1  system clock; one clock domain for the whole block
- `rstn`  in  1  reset; synchronous, active-low
- `pixel_valid`  in  1  input pixel strobe from the display engine
- `pixel`  in  1  input pixel value (1 = lit)
- `pixel_ready`  out  1  FIFO not full; combinational from FIFO state
- `vid_ce`  in  1  pixel-clock enable; one raster slot per asserted cycle
- `vid_hsync`  out  1  horizontal sync, active-low
- `vid_vsync`  out  1  vertical sync, active-low
- `vid_de`  out  1  data enable (active region)
- `vid_pixel`  out  1  output pixel; 0 whenever `vid_de`=0
- `frame_start`  out  1  one-`clk` pulse requesting a new frame fetch
- `underflow`  out  1  sticky; FIFO was empty on an active slot
- `overflow`  out  1  sticky; a pixel arrived while FIFO full
- `clr_err`  in  1  clears both sticky flags

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counters: `hcnt` and `vcnt` are 12 bits and reset to 0.
  - On a `vid_ce` cycle, `hcnt` increments.
  - At H_TOTAL−1, `hcnt` wraps to 0 and `vcnt` increments.
  - At V_TOTAL−1, `vcnt` wraps to 0.
  - With `vid_ce`=0, all raster state and outputs hold.
- Region decode, using counter values before the increment:
  - active = `hcnt`<H_ACTIVE && `vcnt`<V_ACTIVE
  - hsync = `hcnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vsync = `vcnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
- FIFO: FIFO_DEPTH×1 bit, with log2(FIFO_DEPTH)+1-bit read and write pointers.
  - full = pointer MSBs differ and the low bits are equal.
- Push: when `pixel_valid` && `pixel_ready`.
  - `pixel_valid` while full → pixel dropped, `overflow` set.
- Pop: on a `vid_ce` cycle with active=1 and FIFO non-empty.
  - Active slot with FIFO empty → `vid_pixel`=0, `underflow` set, no pop.
- Push and pop in the same cycle are both honoured.
  - Fullness is judged on the pre-cycle state.
  - There is no fall-through: a pixel pushed into an empty FIFO cannot be popped that cycle.
- Frame sync, on a `vid_ce` cycle with `hcnt`=0 and `vcnt`=V_ACTIVE (first blanking line):
  - `frame_start` pulses.
  - The FIFO is flushed: both pointers are set to 0, and any push in that cycle is discarded without setting `overflow`.
  - The display engine starts its next frame fetch on `frame_start` and supplies exactly H_ACTIVE×V_ACTIVE pixels before `vcnt` returns to 0.
  - Misalignment is therefore recovered every frame.
- Sticky flags: `clr_err` clears both flags. A set event in the same cycle as `clr_err` wins.

## Timing
- Reset values while `rstn`=0 and the first cycle after:
  - `vid_hsync`=1, `vid_vsync`=1
  - `vid_de`=0, `vid_pixel`=0
  - `frame_start`=0, `underflow`=0, `overflow`=0
  - FIFO empty, so `pixel_ready`=1
- Reset mid-frame discards FIFO contents and restarts the raster at (0,0).
- All video outputs are registered. Outputs update on the `clk` edge ending a `vid_ce` cycle and reflect that cycle's pre-increment `hcnt`/`vcnt`. Latency from counter to output is 1 `clk`.
- FIFO latency: a pixel pushed at cycle n is poppable from cycle n+1.
- `frame_start` is registered and asserts for 1 `clk` in the cycle after the triggering `vid_ce` cycle. The flush takes effect at the same edge.
- `pixel_ready` changes combinationally with FIFO occupancy, with no registered lag.

## Test plan
- Reset with small parameters (H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1), `vid_ce`=1 constantly, no pixels:
  - `vid_hsync` low for exactly 2 of every 14 slots, starting at slot 10.
  - `vid_vsync` low for line 5 of every 7.
  - `vid_de` high for 8 slots on lines 0–3.
  - `underflow` sets on the first active slot.
- Same parameters, 32 pixels pattern 1010… pushed after `frame_start`:
  - `vid_pixel` reproduces 1010… across all 32 active slots.
  - `underflow` stays 0 and the FIFO is empty at the next `frame_start`.
- FIFO_DEPTH=4, 6 back-to-back pushes with no pops:
  - `pixel_ready` drops after the 4th push.
  - The 5th and 6th pixels are dropped and `overflow`=1.
  - The next 4 active slots output the first 4 pixels.
- `vid_ce` toggling every 3rd cycle:
  - Raster advances one slot per `vid_ce`, and outputs hold between enables.
  - `frame_start` stays a single-cycle pulse.
- Leftover 5 pixels in the FIFO at `frame_start`, plus a push in that same cycle:
  - FIFO is empty afterwards, `overflow` stays 0.
  - First active pixel of the next frame is the first pixel pushed after the pulse.
- `clr_err` asserted in the same cycle as a new underflow event → `underflow` remains 1. `clr_err` alone → both flags are 0 next cycle.
